// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and the 4-bit carry-lookahead function for serial_nibble_adder.
package serial_nibble_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returns {C4, sum[3:0]} using generate/propagate lookahead equations.
    function automatic logic [NIBBLE_W:0] cla4(
        input logic [NIBBLE_W-1:0] x,
        input logic [NIBBLE_W-1:0] y,
        input logic                ci
    );
        logic [NIBBLE_W-1:0] g;
        logic [NIBBLE_W-1:0] p;
        logic [NIBBLE_W:0]   c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[NIBBLE_W-1:0]};
    endfunction

endpackage

// File: rtl/serial_nibble_adder_slice.sv
// Combinational 4-bit lookahead slice; carry into the MSB is exported only
// when SERIAL_NIBBLE_ADDER_OVF_EN is defined.
module nibble_cla_slice
    import serial_nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_nib,
    input  logic [NIBBLE_W-1:0] b_nib,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] sum_nib_c,
    output logic                c4_c
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
    ,
    output logic                c3_c
`endif
);

    assign {c4_c, sum_nib_c} = cla4(a_nib, b_nib, c_in);

`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
    // Carry into bit 3 recovered from sum bit 3 and its propagate term.
    assign c3_c = sum_nib_c[NIBBLE_W-1] ^ a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1];
`endif

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle adder: one 4-bit lookahead slice per clock, LSB nibble first.
// Optional signed-overflow output enabled by SERIAL_NIBBLE_ADDER_OVF_EN.
module serial_nibble_adder
    import serial_nibble_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
        $error("serial_nibble_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_e              state_q;
    state_e              state_d;
    logic                accept;
    logic                last_slice;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                carry_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                c4;
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
    logic                c3;
`endif

    // Select the operand nibbles addressed by the slice counter.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < int'(NIBBLES); k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_nib = a_q[k*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[k*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_cla_slice u_slice (
        .a_nib     (a_nib),
        .b_nib     (b_nib),
        .c_in      (carry_q),
        .sum_nib_c (s_nib),
        .c4_c      (c4)
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
        ,
        .c3_c      (c3)
`endif
    );

    assign last_slice = (cnt_q == CNT_W'(NIBBLES - 1));

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with registered handshake/status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    // Operand capture, per-slice sum write-back and carry chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            carry_q <= c4;
            cnt_q   <= cnt_q + CNT_W'(1);
            for (int k = 0; k < int'(NIBBLES); k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    sum[k*NIBBLE_W +: NIBBLE_W] <= s_nib;
                end
            end
            if (last_slice) begin
                c_out <= c4;
`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
                ovf   <= c3 ^ c4;
`endif
            end
        end
    end

endmodule
